frac_baud_generator: RTL and testbench

// - Parametrised successor to the fixed-table UART baud generator.
// - Produces the 16x-style oversample tick from a run-time divisor with a fractional part,
//   so any baud rate can be programmed at any clock frequency.
// - Also produces bit-rate and mid-bit ticks, so UART Rx/Tx need no local oversample counters.
// - Sits between the UART control/config registers and the uart_rx/uart_tx datapaths.

---
 rtl/baud_gen_pkg.sv | 62 ++++++
 rtl/frac_baud_generator_if.sv | 31 +++
 rtl/frac_tick_divider.sv | 87 ++++++++
 rtl/frac_baud_generator.sv | 68 ++++++
 tb/tb_frac_baud_generator.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/baud_gen_pkg.sv
// Shared constants and helpers for the fractional baud generator.
// Includes the default widths and the 50 MHz divisor table for common baud rates.
package baud_gen_pkg;

  localparam int unsigned OVERSAMPLE_DEF     = 16;
  localparam int unsigned DIV_INT_WIDTH_DEF  = 16;
  localparam int unsigned DIV_FRAC_WIDTH_DEF = 4;

  // Divisors at 50 MHz with 16x oversampling (integer / sixteenths)
  localparam int unsigned DIV_INT_9600    = 325;
  localparam int unsigned DIV_FRAC_9600   = 8;
  localparam int unsigned DIV_INT_19200   = 162;
  localparam int unsigned DIV_FRAC_19200  = 12;
  localparam int unsigned DIV_INT_115200  = 27;
  localparam int unsigned DIV_FRAC_115200 = 2;
  localparam int unsigned DIV_INT_256000  = 12;
  localparam int unsigned DIV_FRAC_256000 = 3;

  typedef enum logic [1:0] {
    BAUD_9600,
    BAUD_19200,
    BAUD_115200,
    BAUD_256000
  } baud_sel_e;

  typedef struct packed {
    logic [DIV_INT_WIDTH_DEF-1:0]  div_int;
    logic [DIV_FRAC_WIDTH_DEF-1:0] div_frac;
  } baud_div_t;

  function automatic baud_div_t baud_div_50mhz(input baud_sel_e sel);
    baud_div_t d;
    d.div_int  = DIV_INT_WIDTH_DEF'(DIV_INT_9600);
    d.div_frac = DIV_FRAC_WIDTH_DEF'(DIV_FRAC_9600);
    case (sel)
      BAUD_19200: begin
        d.div_int  = DIV_INT_WIDTH_DEF'(DIV_INT_19200);
        d.div_frac = DIV_FRAC_WIDTH_DEF'(DIV_FRAC_19200);
      end
      BAUD_115200: begin
        d.div_int  = DIV_INT_WIDTH_DEF'(DIV_INT_115200);
        d.div_frac = DIV_FRAC_WIDTH_DEF'(DIV_FRAC_115200);
      end
      BAUD_256000: begin
        d.div_int  = DIV_INT_WIDTH_DEF'(DIV_INT_256000);
        d.div_frac = DIV_FRAC_WIDTH_DEF'(DIV_FRAC_256000);
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frac_baud_generator_if.sv
// Config/tick bus between the UART register block (master) and the baud generator (slave).
interface frac_baud_generator_if
  import baud_gen_pkg::*;
#(
  parameter int unsigned DIV_INT_WIDTH  = DIV_INT_WIDTH_DEF,
  parameter int unsigned DIV_FRAC_WIDTH = DIV_FRAC_WIDTH_DEF,
  parameter int unsigned PHASE_W        = clog2(OVERSAMPLE_DEF)
);

  logic                      en_i;
  logic [DIV_INT_WIDTH-1:0]  div_int_i;
  logic [DIV_FRAC_WIDTH-1:0] div_frac_i;
  logic                      div_valid_i;
  logic                      div_ready_o;
  logic                      bit_sync_i;
  logic                      sample_en_o;
  logic                      bit_en_o;
  logic                      mid_bit_en_o;
  logic [PHASE_W-1:0]        os_phase_o;

  modport master (
    output en_i, div_int_i, div_frac_i, div_valid_i, bit_sync_i,
    input  div_ready_o, sample_en_o, bit_en_o, mid_bit_en_o, os_phase_o
  );

  modport slave (
    input  en_i, div_int_i, div_frac_i, div_valid_i, bit_sync_i,
    output div_ready_o, sample_en_o, bit_en_o, mid_bit_en_o, os_phase_o
  );

endinterface

// File: rtl/frac_tick_divider.sv
// Fractional clock divider: divisor shadow/handshake, cycle counter and fraction accumulator.
// Emits tick_c on the last cycle of each sample period and a registered sample_en after it.
module frac_tick_divider #(
  parameter int unsigned DIV_INT_WIDTH  = 16,
  parameter int unsigned DIV_FRAC_WIDTH = 4,
  parameter int unsigned RESET_DIV_INT  = 325,
  parameter int unsigned RESET_DIV_FRAC = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en,
  input  logic                      sync,
  input  logic [DIV_INT_WIDTH-1:0]  div_int,
  input  logic [DIV_FRAC_WIDTH-1:0] div_frac,
  input  logic                      div_valid,
  output logic                      div_ready,
  output logic                      tick_c,
  output logic                      sample_en
);

  localparam int unsigned CNT_W = DIV_INT_WIDTH + 1;
  localparam logic [DIV_INT_WIDTH-1:0] RST_INT =
    (RESET_DIV_INT == 0) ? DIV_INT_WIDTH'(1) : DIV_INT_WIDTH'(RESET_DIV_INT);
  localparam logic [DIV_FRAC_WIDTH-1:0] RST_FRAC = DIV_FRAC_WIDTH'(RESET_DIV_FRAC);

  logic [DIV_INT_WIDTH-1:0]  div_int_r, shadow_int_r;
  logic [DIV_FRAC_WIDTH-1:0] div_frac_r, shadow_frac_r, frac_acc_r;
  logic                      carry_r, pending_r, ready_r, sample_en_r;
  logic [CNT_W-1:0]          cnt_r, period_c;
  logic [DIV_FRAC_WIDTH:0]   acc_sum_c;
  logic                      capture_c, apply_c;

  // Period stretches by one cycle whenever the last tick's fraction add carried out
  always_comb begin
    period_c  = CNT_W'(div_int_r) + CNT_W'(carry_r);
    acc_sum_c = {1'b0, frac_acc_r} + {1'b0, div_frac_r};
    tick_c    = en && !sync && (cnt_r >= period_c - CNT_W'(1));
    capture_c = div_valid && ready_r;
    apply_c   = pending_r && (!en || sample_en_r);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_int_r     <= RST_INT;
      div_frac_r    <= RST_FRAC;
      shadow_int_r  <= RST_INT;
      shadow_frac_r <= RST_FRAC;
      frac_acc_r    <= '0;
      carry_r       <= 1'b0;
      cnt_r         <= '0;
      pending_r     <= 1'b0;
      ready_r       <= 1'b1;
      sample_en_r   <= 1'b0;
    end else begin
      sample_en_r <= tick_c;
      if (!en || sync) begin
        cnt_r      <= '0;
        frac_acc_r <= '0;
        carry_r    <= 1'b0;
      end else begin
        cnt_r <= tick_c ? '0 : cnt_r + CNT_W'(1);
        if (apply_c) begin
          frac_acc_r <= '0;
          carry_r    <= 1'b0;
        end else if (tick_c) begin
          {carry_r, frac_acc_r} <= acc_sum_c;
        end
      end
      // New divisor waits in the shadow until a tick boundary (or en low) so no period is cut short
      if (capture_c) begin
        shadow_int_r  <= (div_int == '0) ? DIV_INT_WIDTH'(1) : div_int;
        shadow_frac_r <= div_frac;
        pending_r     <= 1'b1;
        ready_r       <= 1'b0;
      end else if (apply_c) begin
        div_int_r  <= shadow_int_r;
        div_frac_r <= shadow_frac_r;
        pending_r  <= 1'b0;
        ready_r    <= 1'b1;
      end
    end
  end

  assign div_ready = ready_r;
  assign sample_en = sample_en_r;

endmodule

// File: rtl/frac_baud_generator.sv
// Fractional baud generator: oversample tick plus bit-end and mid-bit ticks and the
// oversample phase index, with run-time divisor updates and Rx bit-phase realignment.
module frac_baud_generator
  import baud_gen_pkg::*;
#(
  parameter int unsigned DIV_INT_WIDTH  = DIV_INT_WIDTH_DEF,
  parameter int unsigned DIV_FRAC_WIDTH = DIV_FRAC_WIDTH_DEF,
  parameter int unsigned OVERSAMPLE     = OVERSAMPLE_DEF,
  parameter int unsigned RESET_DIV_INT  = DIV_INT_9600,
  parameter int unsigned RESET_DIV_FRAC = DIV_FRAC_9600
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  frac_baud_generator_if.slave    bus
);

  localparam int unsigned PHASE_W = clog2(OVERSAMPLE);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [PHASE_W-1:0] PHASE_MID  = PHASE_W'(OVERSAMPLE / 2);

  logic               tick_c, div_ready, sample_en;
  logic [PHASE_W-1:0] phase_r, phase_inc_c;
  logic               bit_en_r, mid_bit_en_r;

  frac_tick_divider #(
    .DIV_INT_WIDTH  (DIV_INT_WIDTH),
    .DIV_FRAC_WIDTH (DIV_FRAC_WIDTH),
    .RESET_DIV_INT  (RESET_DIV_INT),
    .RESET_DIV_FRAC (RESET_DIV_FRAC)
  ) u_div (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en        (bus.en_i),
    .sync      (bus.bit_sync_i),
    .div_int   (bus.div_int_i),
    .div_frac  (bus.div_frac_i),
    .div_valid (bus.div_valid_i),
    .div_ready (div_ready),
    .tick_c    (tick_c),
    .sample_en (sample_en)
  );

  always_comb phase_inc_c = (phase_r == PHASE_LAST) ? '0 : phase_r + PHASE_W'(1);

  // Phase and bit decodes register alongside sample_en so all ticks line up on one cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_r      <= '0;
      bit_en_r     <= 1'b0;
      mid_bit_en_r <= 1'b0;
    end else if (!bus.en_i || bus.bit_sync_i) begin
      phase_r      <= '0;
      bit_en_r     <= 1'b0;
      mid_bit_en_r <= 1'b0;
    end else begin
      bit_en_r     <= tick_c && (phase_r == PHASE_LAST);
      mid_bit_en_r <= tick_c && (phase_inc_c == PHASE_MID);
      if (tick_c) phase_r <= phase_inc_c;
    end
  end

  assign bus.div_ready_o  = div_ready;
  assign bus.sample_en_o  = sample_en;
  assign bus.bit_en_o     = bit_en_r;
  assign bus.mid_bit_en_o = mid_bit_en_r;
  assign bus.os_phase_o   = phase_r;

endmodule

// File: tb/tb_frac_baud_generator.sv
// Bench for frac_baud_generator: tick times predicted from T(n) = n*D + floor((n-1)*F/16)
// measured from each counter restart, plus phase, bit/mid-bit and handshake expectations.
module tb_frac_baud_generator;
  import baud_gen_pkg::*;

  localparam int unsigned IW = 16;
  localparam int unsigned FW = 4;
  localparam int unsigned OS = 16;
  localparam int unsigned PW = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;
  int stray = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  frac_baud_generator_if #(.DIV_INT_WIDTH(IW), .DIV_FRAC_WIDTH(FW), .PHASE_W(PW)) bus ();

  frac_baud_generator #(
    .DIV_INT_WIDTH (IW),
    .DIV_FRAC_WIDTH(FW),
    .OVERSAMPLE    (OS),
    .RESET_DIV_INT (325),
    .RESET_DIV_FRAC(8)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    if ((bus.bit_en_o || bus.mid_bit_en_o) && !bus.sample_en_o) stray++;
  endtask

  // Cycles from a counter restart to the n-th tick
  function automatic int unsigned t_model(input int unsigned d, input int unsigned f,
                                          input int unsigned n);
    int unsigned dd;
    dd = (d == 0) ? 1 : d;
    return n * dd + (((n - 1) * f) >> FW);
  endfunction

  task automatic program_div(input int unsigned d, input int unsigned f);
    bus.div_int_i   = IW'(d);
    bus.div_frac_i  = FW'(f);
    bus.div_valid_i = 1'b1;
    step();
    bus.div_valid_i = 1'b0;
  endtask

  task automatic run_ticks(input string tag, input int unsigned d, input int unsigned f,
                           input int unsigned r, input int unsigned n_first,
                           input int unsigned n_cnt, inout int unsigned phase,
                           output int unsigned last_t);
    int unsigned limit;
    last_t = cyc;
    for (int unsigned n = n_first; n < n_first + n_cnt; n++) begin
      limit = r + t_model(d, f, n) + 4;
      do step(); while (!bus.sample_en_o && cyc < limit);
      if (!bus.sample_en_o) begin
        check({tag, "_tick_seen"}, 32'(bus.sample_en_o), 1);
        return;
      end
      phase = (phase + 1) % OS;
      check({tag, "_time"}, cyc - r, t_model(d, f, n));
      check({tag, "_phase"}, 32'(bus.os_phase_o), phase);
      check({tag, "_bit_en"}, 32'(bus.bit_en_o), (phase == 0) ? 1 : 0);
      check({tag, "_mid_en"}, 32'(bus.mid_bit_en_o), (phase == OS / 2) ? 1 : 0);
      last_t = cyc;
    end
  endtask

  initial begin
    int unsigned r, phase, t1, tl, d, f, d2, f2, k, n;

    rst_i           = 1'b1;
    bus.en_i        = 1'b0;
    bus.div_int_i   = '0;
    bus.div_frac_i  = '0;
    bus.div_valid_i = 1'b0;
    bus.bit_sync_i  = 1'b0;
    repeat (3) step();
    check("rst_sample_en", 32'(bus.sample_en_o), 0);
    check("rst_bit_en", 32'(bus.bit_en_o), 0);
    check("rst_mid_en", 32'(bus.mid_bit_en_o), 0);
    check("rst_os_phase", 32'(bus.os_phase_o), 0);
    check("rst_ready", 32'(bus.div_ready_o), 1);
    rst_i = 1'b0;
    step();

    // Reset divisor 325/8: 16 periods span 5208 cycles
    bus.en_i = 1'b1;
    r = cyc; phase = 0;
    run_ticks("rst_div", 325, 8, r, 1, 1, phase, t1);
    run_ticks("rst_div", 325, 8, r, 2, 16, phase, tl);
    check("rst_div_16_periods", tl - t1, 5208);

    // 27/2 programmed while disabled
    bus.en_i = 1'b0;
    step();
    check("en_low_sample", 32'(bus.sample_en_o), 0);
    check("en_low_phase", 32'(bus.os_phase_o), 0);
    program_div(27, 2);
    check("idle_cap_ready", 32'(bus.div_ready_o), 0);
    step();
    check("idle_apply_ready", 32'(bus.div_ready_o), 1);
    bus.en_i = 1'b1;
    r = cyc; phase = 0;
    run_ticks("d27", 27, 2, r, 1, 1, phase, t1);
    run_ticks("d27", 27, 2, r, 2, 16, phase, tl);
    check("d27_16_periods", tl - t1, 434);

    // Update to 12/0 mid-period: old period finishes, then 12-cycle periods
    repeat (10) step();
    program_div(12, 0);
    check("upd_ready_low", 32'(bus.div_ready_o), 0);
    run_ticks("upd_old", 27, 2, r, 18, 1, phase, tl);
    check("upd_ready_at_tick", 32'(bus.div_ready_o), 0);
    step();
    check("upd_ready_after", 32'(bus.div_ready_o), 1);
    r = tl;
    run_ticks("upd_new", 12, 0, r, 1, 4, phase, tl);

    // Sync at phase 5, cnt 10
    n = (5 + OS - phase) % OS;
    if (n == 0) n = OS;
    run_ticks("pre_sync", 12, 0, r, 5, n, phase, tl);
    check("pre_sync_phase", 32'(bus.os_phase_o), 5);
    repeat (10) step();
    bus.bit_sync_i = 1'b1;
    step();
    bus.bit_sync_i = 1'b0;
    check("sync_phase", 32'(bus.os_phase_o), 0);
    check("sync_no_tick", 32'(bus.sample_en_o), 0);
    r = cyc; phase = 0;
    run_ticks("post_sync", 12, 0, r, 1, 16, phase, tl);
    check("stray_a", stray, 0);

    // Degenerate divisors: 0/0 ticks every cycle, 1/8 alternates 1 and 2
    bus.en_i = 1'b0;
    step();
    program_div(0, 0);
    step();
    bus.en_i = 1'b1;
    r = cyc; phase = 0;
    run_ticks("d0", 0, 0, r, 1, 20, phase, tl);
    bus.en_i = 1'b0;
    step();
    program_div(1, 8);
    step();
    check("d1_ready", 32'(bus.div_ready_o), 1);
    bus.en_i = 1'b1;
    r = cyc; phase = 0;
    run_ticks("d1f8", 1, 8, r, 1, 20, phase, tl);

    // Randomised divisors, sync points and live updates
    for (int round = 0; round < 3; round++) begin
      d  = $urandom_range(40, 2);
      f  = $urandom_range(15, 0);
      d2 = $urandom_range(40, 2);
      f2 = $urandom_range(15, 0);
      bus.en_i = 1'b0;
      step();
      program_div(d, f);
      step();
      bus.en_i = 1'b1;
      r = cyc; phase = 0;
      run_ticks("rnd", d, f, r, 1, 12, phase, tl);
      k = $urandom_range(d - 1, 0);
      repeat (k) step();
      bus.bit_sync_i = 1'b1;
      step();
      bus.bit_sync_i = 1'b0;
      check("rnd_sync_phase", 32'(bus.os_phase_o), 0);
      r = cyc; phase = 0;
      run_ticks("rnd_sync", d, f, r, 1, 10, phase, tl);
      program_div(d2, f2);
      check("rnd_upd_ready_low", 32'(bus.div_ready_o), 0);
      run_ticks("rnd_upd_old", d, f, r, 11, 1, phase, tl);
      step();
      check("rnd_upd_ready", 32'(bus.div_ready_o), 1);
      r = tl;
      run_ticks("rnd_upd_new", d2, f2, r, 1, 10, phase, tl);
    end

    // Reset mid-bit with a divisor pending
    bus.en_i = 1'b0;
    step();
    program_div(40, 0);
    step();
    bus.en_i = 1'b1;
    r = cyc; phase = 0;
    run_ticks("pre_rst", 40, 0, r, 1, 2, phase, tl);
    repeat (3) step();
    program_div(7, 0);
    check("pend_ready_low", 32'(bus.div_ready_o), 0);
    repeat (2) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid_rst_sample", 32'(bus.sample_en_o), 0);
    check("mid_rst_bit", 32'(bus.bit_en_o), 0);
    check("mid_rst_mid", 32'(bus.mid_bit_en_o), 0);
    check("mid_rst_phase", 32'(bus.os_phase_o), 0);
    check("mid_rst_ready", 32'(bus.div_ready_o), 1);
    r = cyc; phase = 0;
    run_ticks("post_rst", 325, 8, r, 1, 4, phase, tl);
    check("post_rst_ready", 32'(bus.div_ready_o), 1);
    check("stray_b", stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
